// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: registered one-hot grant held for up to weight[i]
// accepted beats, with early release when the owner drops its request.
module wrr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WEIGHT_W = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*WEIGHT_W-1:0]   weight_i,
  input  logic                          gnt_ready_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic                          gnt_valid_o,
  output logic [IDX_W-1:0]              gnt_idx_o,
  output logic [WEIGHT_W-1:0]           credit_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state_q, state_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic                  valid_q, valid_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]   credit_q, credit_d;

  logic                  beat, release_own;
  logic [IDX_W-1:0]      search_ptr;
  logic [IDX_W:0]        pick_res;
  logic [WEIGHT_W-1:0]   wsel;

  // Returns {found, index}; scans from p+1 around to p itself, nearest offset wins.
  function automatic logic [IDX_W:0] pick(input logic [NUM_REQ-1:0] r,
                                          input logic [IDX_W-1:0]   p);
    logic [IDX_W:0] res;
    int             c;
    res = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      c = (int'(p) + i) % NUM_REQ;
      if (r[c]) res = {1'b1, IDX_W'(c)};
    end
    return res;
  endfunction

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    valid_d     = valid_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    credit_d    = credit_q;
    beat        = (state_q == GRANT) && gnt_ready_i;
    release_own = (state_q == GRANT) &&
                  (!req_i[idx_q] || (beat && credit_q == WEIGHT_W'(1)));
    search_ptr  = release_own ? idx_q : ptr_q;
    pick_res    = pick(req_i, search_ptr);
    wsel        = weight_i[pick_res[IDX_W-1:0]*WEIGHT_W +: WEIGHT_W];

    if (state_q == IDLE || release_own) begin
      ptr_d = search_ptr;
      if (pick_res[IDX_W]) begin
        state_d  = GRANT;
        idx_d    = pick_res[IDX_W-1:0];
        gnt_d    = NUM_REQ'(1) << pick_res[IDX_W-1:0];
        valid_d  = 1'b1;
        credit_d = (wsel == '0) ? WEIGHT_W'(1) : wsel;
      end else begin
        state_d  = IDLE;
        idx_d    = '0;
        gnt_d    = '0;
        valid_d  = 1'b0;
        credit_d = '0;
      end
    end else if (beat) begin
      credit_d = credit_q - WEIGHT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      ptr_q    <= IDX_W'(NUM_REQ - 1);
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = valid_q;
  assign gnt_idx_o   = idx_q;
  assign credit_o    = credit_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter: one vector per clock, outputs sampled 1 time unit after the edge.
module tb_wrr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] weight;
  logic        gnt_ready;
  logic [3:0]  gnt;
  logic        gnt_valid;
  logic [1:0]  gnt_idx;
  logic [3:0]  credit;

  int errors = 0;
  int checks = 0;

  wrr_arbiter #(.NUM_REQ(4), .WEIGHT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .weight_i    (weight),
    .gnt_ready_i (gnt_ready),
    .gnt_o       (gnt),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx),
    .credit_o    (credit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [3:0]  q;
    logic [15:0] w;
    logic        rd;
    logic [3:0]  eg;
    logic [1:0]  ei;
    logic [3:0]  ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic r, input logic [3:0] q, input logic [15:0] w,
                             input logic rd, input logic [3:0] eg, input logic [1:0] ei,
                             input logic [3:0] ec);
    vec_t x;
    x.r = r; x.q = q; x.w = w; x.rd = rd; x.eg = eg; x.ei = ei; x.ec = ec;
    return x;
  endfunction

  // Drive one cycle of inputs, clock once, then compare all outputs.
  task automatic step(input logic r, input logic [3:0] q, input logic [15:0] w,
                      input logic rd, input logic [3:0] eg, input logic [1:0] ei,
                      input logic [3:0] ec, input string name);
    logic [10:0] act, exp;
    rst = r; req = q; weight = w; gnt_ready = rd;
    @(posedge clk);
    #1;
    act = {gnt, gnt_valid, gnt_idx, credit};
    exp = {eg, |eg, ei, ec};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got gnt=%b valid=%b idx=%0d credit=%0d, want gnt=%b valid=%b idx=%0d credit=%0d",
               name, gnt, gnt_valid, gnt_idx, credit, eg, |eg, ei, ec);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; weight = '0; gnt_ready = 1'b0;

    // reset held with all requesting
    repeat (3) tbl.push_back(v(1, 4'hF, 16'h0213, 1, 4'b0000, 0, 0));
    // weighted rotation {3,1,2,0}: 0,0,0,1,2,2,3 twice
    for (int k = 0; k < 2; k++) begin
      tbl.push_back(v(0, 4'hF, 16'h0213, 1, 4'b0001, 0, 3));
      tbl.push_back(v(0, 4'hF, 16'h0213, 1, 4'b0001, 0, 2));
      tbl.push_back(v(0, 4'hF, 16'h0213, 1, 4'b0001, 0, 1));
      tbl.push_back(v(0, 4'hF, 16'h0213, 1, 4'b0010, 1, 1));
      tbl.push_back(v(0, 4'hF, 16'h0213, 1, 4'b0100, 2, 2));
      tbl.push_back(v(0, 4'hF, 16'h0213, 1, 4'b0100, 2, 1));
      tbl.push_back(v(0, 4'hF, 16'h0213, 1, 4'b1000, 3, 1));
    end
    // stall: owner 0 credit 2, requester 1 waiting cannot preempt
    tbl.push_back(v(1, 4'h3, 16'h0002, 0, 4'b0000, 0, 0));
    tbl.push_back(v(0, 4'h3, 16'h0002, 0, 4'b0001, 0, 2));
    repeat (5) tbl.push_back(v(0, 4'h3, 16'h0002, 0, 4'b0001, 0, 2));
    tbl.push_back(v(0, 4'h3, 16'h0002, 1, 4'b0001, 0, 1));
    tbl.push_back(v(0, 4'h3, 16'h0002, 1, 4'b0010, 1, 1));
    // withdrawal with nobody else -> idle, then ptr=1 makes 2 beat 0
    tbl.push_back(v(1, 4'h0, 16'h0231, 0, 4'b0000, 0, 0));
    tbl.push_back(v(0, 4'h2, 16'h0231, 0, 4'b0010, 1, 3));
    tbl.push_back(v(0, 4'h2, 16'h0231, 1, 4'b0010, 1, 2));
    tbl.push_back(v(0, 4'h0, 16'h0231, 1, 4'b0000, 0, 0));
    tbl.push_back(v(0, 4'h5, 16'h0231, 0, 4'b0100, 2, 2));
    tbl.push_back(v(0, 4'h1, 16'h0231, 0, 4'b0001, 0, 1));
    // withdrawal moves directly to next requester after ptr=1
    tbl.push_back(v(1, 4'h0, 16'h0231, 0, 4'b0000, 0, 0));
    tbl.push_back(v(0, 4'h2, 16'h0231, 0, 4'b0010, 1, 3));
    tbl.push_back(v(0, 4'h2, 16'h0231, 1, 4'b0010, 1, 2));
    tbl.push_back(v(0, 4'hD, 16'h0231, 0, 4'b0100, 2, 2));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].q, tbl[i].w, tbl[i].rd, tbl[i].ec == 0 ? 4'b0000 : tbl[i].eg,
           tbl[i].ei, tbl[i].ec, $sformatf("vec%0d", i));
    end

    // sole requester 2, weight 2: continuous grant, credit 2,1,2,1
    step(1, 4'h0, 16'h0200, 1, 4'b0000, 0, 0, "sole_rst");
    for (int k = 0; k < 3; k++) begin
      step(0, 4'h4, 16'h0200, 1, 4'b0100, 2, 2, "sole_c2");
      step(0, 4'h4, 16'h0200, 1, 4'b0100, 2, 1, "sole_c1");
    end

    // reset mid-tenure: owner 3 with credit 4
    step(1, 4'h0, 16'h4000, 0, 4'b0000, 0, 0, "mid_rst0");
    step(0, 4'h8, 16'h4000, 0, 4'b1000, 3, 4, "mid_grant");
    step(1, 4'h8, 16'h4000, 1, 4'b0000, 0, 0, "mid_rst");
    step(0, 4'h8, 16'h4000, 1, 4'b1000, 3, 4, "mid_regrant");
    step(0, 4'h8, 16'h4000, 1, 4'b1000, 3, 3, "mid_beat");

    // reset restores ptr: after owner 0 releases (ptr=0), reset must put 0 first again
    step(1, 4'h0, 16'h0001, 1, 4'b0000, 0, 0, "ptr_rst0");
    step(0, 4'h1, 16'h0001, 1, 4'b0001, 0, 1, "ptr_g0");
    step(0, 4'h1, 16'h0001, 1, 4'b0001, 0, 1, "ptr_regrant0");
    step(1, 4'h9, 16'h0001, 1, 4'b0000, 0, 0, "ptr_rst");
    step(0, 4'h9, 16'h0001, 0, 4'b0001, 0, 1, "ptr_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
